// File: rtl/alu_mdu.sv
// alu_mdu: handshaked RV32I ALU with registered NZCV result and iterative RV32M multiply/divide.
// Latency: 1 cycle for base ops, WIDTH+1 for MUL class, WIDTH+2 for DIV class (fixed, operand independent).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE or while draining DONE.
// Optional divider: define ALU_MDU_DIV_EN to build it; otherwise DIV-class opcodes complete in one cycle with Result=0, Z=1.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       Flags,
    output logic             busy
);

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_AND    = 5'b00010;
    localparam logic [4:0] OP_OR     = 5'b00011;
    localparam logic [4:0] OP_SLT    = 5'b00101;
    localparam logic [4:0] OP_SLL    = 5'b00110;
    localparam logic [4:0] OP_SRL    = 5'b00111;
    localparam logic [4:0] OP_XOR    = 5'b01000;
    localparam logic [4:0] OP_SLTU   = 5'b01001;
    localparam logic [4:0] OP_SRA    = 5'b01010;
    localparam logic [4:0] OP_LUI    = 5'b01011;
    localparam logic [4:0] OP_AUIPC  = 5'b01100;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [SHW:0] CNT_MUL_LAST = (SHW+1)'(WIDTH - 1);

    // ---------------- state ----------------
    logic [1:0]         r_state;
    logic [SHW:0]       r_cnt;
    logic [4:0]         r_op;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mcand;
    logic               r_neg;

    // ---------------- handshake / decode ----------------
    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_MUL) || (r_state == S_DIV);
    assign Result    = r_result;
    assign Flags     = r_flags;

    assign w_accept   = in_valid && in_ready;
    assign w_is_mul   = (ALUControl[4:2] == 3'b100);
    assign w_is_div   = (ALUControl[4:2] == 3'b101);
    // MUL/MULH/MULHSU treat A as signed, MUL/MULH treat B as signed; DIV/REM (bit0=0) are signed.
    assign w_a_signed = w_is_mul ? (ALUControl[1:0] != 2'b11) : !ALUControl[0];
    assign w_b_signed = w_is_mul ? !ALUControl[1] : !ALUControl[0];
    assign w_a_neg    = w_a_signed && A[WIDTH-1];
    assign w_b_neg    = w_b_signed && B[WIDTH-1];
    assign w_a_mag    = w_a_neg ? -A : A;
    assign w_b_mag    = w_b_neg ? -B : B;

    // ---------------- single-cycle ALU ----------------
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_b12;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_auipc;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;
    logic             w_alu_v;
    logic             w_nz_en;
    logic [3:0]       w_alu_flags;

    assign w_shamt = B[SHW-1:0];
    assign w_b12   = B << 12;
    assign w_add   = {1'b0, A} + {1'b0, B};
    assign w_sub   = {1'b0, A} - {1'b0, B};
    assign w_auipc = {1'b0, A} + {1'b0, w_b12};

    // Base-op result and flags; unknown opcodes force every flag to zero.
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        w_nz_en   = 1'b1;
        case (ALUControl)
            OP_ADD: begin
                w_alu_res = w_add[WIDTH-1:0];
                w_alu_c   = w_add[WIDTH];
                w_alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_res = w_sub[WIDTH-1:0];
                w_alu_c   = !w_sub[WIDTH];   // no borrow means A >= B unsigned
                w_alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:   w_alu_res = A & B;
            OP_OR:    w_alu_res = A | B;
            OP_XOR:   w_alu_res = A ^ B;
            OP_SLT:   w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU:  w_alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLL:   w_alu_res = A << w_shamt;
            OP_SRL:   w_alu_res = A >> w_shamt;
            OP_SRA:   w_alu_res = WIDTH'($signed(A) >>> w_shamt);
            OP_LUI:   w_alu_res = w_b12;
            OP_AUIPC: begin
                w_alu_res = w_auipc[WIDTH-1:0];
                w_alu_c   = w_auipc[WIDTH];
                w_alu_v   = (A[WIDTH-1] == w_b12[WIDTH-1]) && (w_auipc[WIDTH-1] != A[WIDTH-1]);
            end
            // Reached only without the divider: zero result, so Z comes out set.
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: w_alu_res = '0;
            default: w_nz_en = 1'b0;
        endcase
        w_alu_flags = w_nz_en ? {w_alu_res[WIDTH-1], (w_alu_res == '0), w_alu_c, w_alu_v} : 4'b0000;
    end

    // ---------------- shift-add multiplier ----------------
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_mul_fix;
    logic [WIDTH-1:0]   w_mul_res;

    assign w_mul_sum  = r_prod[0] ? ({1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand})
                                  : {1'b0, r_prod[2*WIDTH-1:WIDTH]};
    assign w_mul_next = {w_mul_sum, r_prod[WIDTH-1:1]};
    assign w_mul_fix  = r_neg ? -w_mul_next : w_mul_next;
    assign w_mul_res  = (r_op == OP_MUL) ? w_mul_fix[WIDTH-1:0] : w_mul_fix[2*WIDTH-1:WIDTH];

`ifdef ALU_MDU_DIV_EN
    // ---------------- restoring divider ----------------
    localparam logic [SHW:0] CNT_DIV_LAST = (SHW+1)'(WIDTH);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH-1:0] r_a;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_div0;

    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_trial;
    logic [WIDTH-1:0] w_div_rem_n;
    logic [WIDTH-1:0] w_q_final;
    logic [WIDTH-1:0] w_r_final;
    logic [WIDTH-1:0] w_div_res;

    assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_dvsr};
    // A negative trial restores; the shifted remainder then fits in WIDTH bits.
    assign w_div_rem_n = w_div_trial[WIDTH] ? w_div_shift[WIDTH-1:0] : w_div_trial[WIDTH-1:0];
    // Divide by zero overrides the iterated values; MIN/-1 falls out of the magnitude path naturally.
    assign w_q_final   = r_div0 ? '1  : (r_qneg ? -r_quo : r_quo);
    assign w_r_final   = r_div0 ? r_a : (r_rneg ? -r_rem : r_rem);
    assign w_div_res   = r_op[1] ? w_r_final : w_q_final;
`endif

    // Control FSM plus iterative datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_neg    <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_a      <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_div0   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_MUL: begin
                    r_prod <= w_mul_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CNT_MUL_LAST) begin
                        r_result <= w_mul_res;
                        r_flags  <= {w_mul_res[WIDTH-1], (w_mul_res == '0), 2'b00};
                        r_state  <= S_DONE;
                    end
                end
`ifdef ALU_MDU_DIV_EN
                S_DIV: begin
                    if (r_cnt == CNT_DIV_LAST) begin
                        r_result <= w_div_res;
                        r_flags  <= {w_div_res[WIDTH-1], (w_div_res == '0), 2'b00};
                        r_state  <= S_DONE;
                    end else begin
                        r_rem <= w_div_rem_n;
                        r_quo <= {r_quo[WIDTH-2:0], !w_div_trial[WIDTH]};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    // IDLE and DONE share the accept path so a drain can overlap the next issue.
                    if (w_accept) begin
                        r_op <= ALUControl;
                        if (w_is_mul) begin
                            r_prod  <= {{WIDTH{1'b0}}, w_b_mag};
                            r_mcand <= w_a_mag;
                            r_neg   <= w_a_neg ^ w_b_neg;
                            r_cnt   <= '0;
                            r_state <= S_MUL;
`ifdef ALU_MDU_DIV_EN
                        end else if (w_is_div) begin
                            r_rem   <= '0;
                            r_quo   <= w_a_mag;
                            r_dvsr  <= w_b_mag;
                            r_a     <= A;
                            r_qneg  <= w_a_neg ^ w_b_neg;
                            r_rneg  <= w_a_neg;
                            r_div0  <= (B == '0);
                            r_cnt   <= '0;
                            r_state <= S_DIV;
`endif
                        end else begin
                            r_result <= w_alu_res;
                            r_flags  <= w_alu_flags;
                            r_state  <= S_DONE;
                        end
                    end else if ((r_state == S_DONE) && out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboarded bench for alu_mdu: driver pushes expected results, monitor pops on each output transfer.
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic [3:0]  Flags;
    logic        busy;

    alu_mdu #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .A          (A),
        .B          (B),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (Result),
        .Flags      (Flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        int          lat;
        int          hs;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];
    exp_t  mon_e;
    string mon_nm;
    bit    lat_done = 1'b0;
    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;

`ifdef ALU_MDU_DIV_EN
    localparam int DLAT = 34;
`else
    localparam int DLAT = 1;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: latency on first valid cycle, value every valid cycle (covers hold stability), pop on transfer.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output Result=%h Flags=%b", Result, Flags);
            end else begin
                mon_e  = exp_q[0];
                mon_nm = nm_q[0];
                if (!lat_done) begin
                    checks++;
                    if (cyc - mon_e.hs != mon_e.lat) begin
                        errors++;
                        $display("FAIL %s latency got=%0d want=%0d", mon_nm, cyc - mon_e.hs, mon_e.lat);
                    end
                    lat_done = 1'b1;
                end
                if (Result !== mon_e.res || Flags !== mon_e.flg) begin
                    errors++;
                    $display("FAIL %s Result=%h Flags=%b want Result=%h Flags=%b",
                             mon_nm, Result, Flags, mon_e.res, mon_e.flg);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(nm_q.pop_front());
                    lat_done = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [3:0] flg, input int lat,
                         input logic ordy, input string nm);
        int n;
        exp_t e;
        @(posedge clk); #1;
        in_valid = 1'b1; ALUControl = op; A = a; B = b; out_ready = ordy;
        #1;
        n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL %s handshake_timeout in_ready=%b want=1", nm, in_ready);
            in_valid = 1'b0;
        end else begin
            e.res = res; e.flg = flg; e.lat = lat; e.hs = cyc;
            exp_q.push_back(e);
            nm_q.push_back(nm);
        end
    endtask

    task automatic drop();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
        end
    endtask

    initial begin
        int bc;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        ALUControl = 5'd0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_result",    Result,             32'd0);
        chk("rst_flags",     {28'd0, Flags},     32'd0);

        // Base ops, issued back to back at one per clock.
        issue(5'b00000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b1001, 1, 1'b1, "add_ovf");
        issue(5'b00001, 32'h5,        32'h5,        32'h0,        4'b0110, 1, 1'b1, "sub_eq");
        issue(5'b01010, 32'h80000000, 32'h24,       32'hF8000000, 4'b1000, 1, 1'b1, "sra");
        issue(5'b00010, 32'hF0,       32'h3C,       32'h30,       4'b0000, 1, 1'b1, "and");
        issue(5'b00001, 32'h3,        32'h5,        32'hFFFFFFFE, 4'b1000, 1, 1'b1, "sub_borrow");
        issue(5'b00000, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b0110, 1, 1'b1, "add_carry");
        issue(5'b00101, 32'hFFFFFFFF, 32'h1,        32'h1,        4'b0000, 1, 1'b1, "slt");
        issue(5'b01001, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b0100, 1, 1'b1, "sltu");
        issue(5'b00110, 32'h1,        32'h21,       32'h2,        4'b0000, 1, 1'b1, "sll");
        issue(5'b00111, 32'h80000000, 32'h1F,       32'h1,        4'b0000, 1, 1'b1, "srl");
        issue(5'b01011, 32'h0,        32'h12345,    32'h12345000, 4'b0000, 1, 1'b1, "lui");
        issue(5'b01100, 32'hFFFFF000, 32'h1,        32'h0,        4'b0110, 1, 1'b1, "auipc_c");
        issue(5'b00011, 32'hF0,       32'h0F,       32'hFF,       4'b0000, 1, 1'b1, "or");
        issue(5'b00100, 32'h0,        32'h0,        32'h0,        4'b0000, 1, 1'b1, "illegal");
        drop();
        drain();

        // MULH with busy-cycle count.
        issue(5'b10001, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 4'b1000, 33, 1'b1, "mulh");
        drop();
        bc = 0;
        for (int n = 0; n < 100; n++) begin
            if (out_valid) break;
            if (busy) bc++;
            @(posedge clk); #1;
        end
        chk("mulh_busy_cycles", bc, 32'd32);
        drain();

        issue(5'b10000, 32'h3,        32'hFFFFFFFC, 32'hFFFFFFF4, 4'b1000, 33, 1'b1, "mul_neg");
        issue(5'b10000, 32'h10000,    32'h10000,    32'h0,        4'b0100, 33, 1'b1, "mul_wrap");
        issue(5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1000, 33, 1'b1, "mulhu");
        issue(5'b10010, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 4'b1000, 33, 1'b1, "mulhsu");
        issue(5'b10001, 32'h40000000, 32'h4,        32'h1,        4'b0000, 33, 1'b1, "mulh_pos");
        drop();
        drain();

`ifdef ALU_MDU_DIV_EN
        issue(5'b10100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 4'b1000, DLAT, 1'b1, "div_neg");
        issue(5'b10110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 4'b1000, DLAT, 1'b1, "rem_neg");
        issue(5'b10101, 32'h5,        32'h0,        32'hFFFFFFFF, 4'b1000, DLAT, 1'b1, "divu_zero");
        issue(5'b10111, 32'h5,        32'h0,        32'h5,        4'b0000, DLAT, 1'b1, "remu_zero");
        issue(5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b1000, DLAT, 1'b1, "div_ovf");
        issue(5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        4'b0100, DLAT, 1'b1, "rem_ovf");
        issue(5'b10101, 32'd100,      32'd7,        32'd14,       4'b0000, DLAT, 1'b1, "divu");
        issue(5'b10111, 32'd100,      32'd7,        32'd2,        4'b0000, DLAT, 1'b1, "remu");
`else
        issue(5'b10100, 32'hFFFFFFF9, 32'h2,        32'h0,        4'b0100, DLAT, 1'b1, "div_off");
        issue(5'b10110, 32'hFFFFFFF9, 32'h2,        32'h0,        4'b0100, DLAT, 1'b1, "rem_off");
        issue(5'b10101, 32'd100,      32'd7,        32'h0,        4'b0100, DLAT, 1'b1, "divu_off");
        issue(5'b10111, 32'd100,      32'd7,        32'h0,        4'b0100, DLAT, 1'b1, "remu_off");
`endif
        drop();
        drain();

        // Back-pressure: hold the ADD result, then drain it and issue XOR in the same cycle.
        issue(5'b00000, 32'h10, 32'h20, 32'h30, 4'b0000, 1, 1'b0, "bp_add");
        drop();
        for (int n = 0; n < 5; n++) begin
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        issue(5'b01000, 32'hFF, 32'h0F, 32'hF0, 4'b0000, 1, 1'b1, "bp_xor");
        drop();
        drain();

        // Reset in the middle of an iterative operation.
        @(posedge clk); #1;
        in_valid = 1'b1; A = 32'd100; B = 32'd7; out_ready = 1'b1;
`ifdef ALU_MDU_DIV_EN
        ALUControl = 5'b10101;
`else
        ALUControl = 5'b10011;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy",      {31'd0, busy},      32'd0);
        chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
        chk("abort_result",    Result,             32'd0);
        chk("abort_flags",     {28'd0, Flags},     32'd0);
        reset = 1'b0;
        issue(5'b00000, 32'd2, 32'd3, 32'd5, 4'b0000, 1, 1'b1, "post_reset_add");
        drop();
        drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
